// File: rtl/macc_pkg.sv
// Shared types and helpers for the dual-lane MAC accumulator: lane widths,
// accumulator FSM states and the clamping add used when saturation is built in.
package macc_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  function automatic int j_w(input int width);
    return 24 + width;
  endfunction

  function automatic int k_w(input int width);
    return 24 - width;
  endfunction

  // Operands live in the low w bits of a and b (w <= 64). The sum is clamped to
  // [-2^(w-1), 2^(w-1)-1] when signed, or [0, 2^(w-1)-1] when unsigned.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          w,
                                          input logic        is_signed);
    logic signed [64:0] sa;
    logic signed [64:0] sb;
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    int                 sh;
    sh = 64 - w;
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    if (is_signed) begin
      sa = 65'($signed(a << sh) >>> sh);
      sb = 65'($signed(b << sh) >>> sh);
      lo = -(65'sd1 <<< (w - 1));
    end else begin
      sa = $signed({1'b0, (a << sh) >> sh});
      sb = $signed({1'b0, (b << sh) >> sh});
      lo = '0;
    end
    s = sa + sb;
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return s[63:0];
  endfunction

endpackage

// File: rtl/macc_valid_pipe.sv
// LAT-deep {valid, last} shift register aligning issue flags with the
// multiplier's product outputs. Synchronous active-high reset.
module macc_valid_pipe #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid_i,
  input  logic in_last_i,
  output logic out_valid_o,
  output logic out_last_o
);

  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      last_q[0]  <= in_last_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[LAT-1];
  assign out_last_o  = last_q[LAT-1];

endmodule

// File: rtl/macc_lane_accum.sv
// Dual-lane dot-product accumulator behind the packed int8 multiplier.
// Define MACC_ACC_SAT_EN to make the lane adds saturate instead of wrap.
module macc_lane_accum
  import macc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIGN      = 1,
  parameter int MACC_LAT  = 4,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 10,
  localparam int J_W      = j_w(WIDTH),
  localparam int K_W      = k_w(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic                 issue_last,
  output logic                 issue_ready,
  input  logic [J_W-1:0]       ji,
  input  logic [K_W-1:0]       ki,
  output logic [ACC_WIDTH-1:0] sum_j,
  output logic [ACC_WIDTH-1:0] sum_k,
  output logic [CNT_WIDTH-1:0] n_terms,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           dbg_state
);

  // Handshakes: an issue happens when issue_valid && issue_ready; a result
  // leaves when out_valid && out_ready, and all outputs hold until then.

  acc_state_t state_q, state_d;

  logic                 issue;
  logic                 term_v;
  logic                 term_l;
  logic [ACC_WIDTH-1:0] ext_j;
  logic [ACC_WIDTH-1:0] ext_k;
  logic [ACC_WIDTH-1:0] add_j;
  logic [ACC_WIDTH-1:0] add_k;
  logic [ACC_WIDTH-1:0] acc_j_q, acc_j_d;
  logic [ACC_WIDTH-1:0] acc_k_q, acc_k_d;
  logic [ACC_WIDTH-1:0] sum_j_q, sum_j_d;
  logic [ACC_WIDTH-1:0] sum_k_q, sum_k_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] n_terms_q, n_terms_d;

  assign issue = issue_valid && issue_ready;

  macc_valid_pipe #(
    .LAT (MACC_LAT)
  ) u_valid_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (issue),
    .in_last_i   (issue && issue_last),
    .out_valid_o (term_v),
    .out_last_o  (term_l)
  );

  if (SIGN == 1) begin : g_sext
    assign ext_j = ACC_WIDTH'($signed(ji));
    assign ext_k = ACC_WIDTH'($signed(ki));
  end else begin : g_zext
    assign ext_j = ACC_WIDTH'(ji);
    assign ext_k = ACC_WIDTH'(ki);
  end

`ifdef MACC_ACC_SAT_EN
  assign add_j = ACC_WIDTH'(sat_add(64'(acc_j_q), 64'(ext_j), ACC_WIDTH, SIGN == 1));
  assign add_k = ACC_WIDTH'(sat_add(64'(acc_k_q), 64'(ext_k), ACC_WIDTH, SIGN == 1));
`else
  assign add_j = acc_j_q + ext_j;
  assign add_k = acc_k_q + ext_k;
`endif

  always_comb begin
    state_d     = state_q;
    issue_ready = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      ACCUM: begin
        issue_ready = 1'b1;
        if (issue_valid && issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (term_v && term_l) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Terms arriving after the last one are impossible: issue stalls until HOLD ends.
  always_comb begin
    acc_j_d   = acc_j_q;
    acc_k_d   = acc_k_q;
    cnt_d     = cnt_q;
    sum_j_d   = sum_j_q;
    sum_k_d   = sum_k_q;
    n_terms_d = n_terms_q;
    if (term_v) begin
      if (term_l) begin
        sum_j_d   = add_j;
        sum_k_d   = add_k;
        n_terms_d = cnt_q + CNT_WIDTH'(1);
        acc_j_d   = '0;
        acc_k_d   = '0;
        cnt_d     = '0;
      end else begin
        acc_j_d = add_j;
        acc_k_d = add_k;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      acc_j_q   <= '0;
      acc_k_q   <= '0;
      cnt_q     <= '0;
      sum_j_q   <= '0;
      sum_k_q   <= '0;
      n_terms_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_j_q   <= acc_j_d;
      acc_k_q   <= acc_k_d;
      cnt_q     <= cnt_d;
      sum_j_q   <= sum_j_d;
      sum_k_q   <= sum_k_d;
      n_terms_q <= n_terms_d;
    end
  end

  assign sum_j     = sum_j_q;
  assign sum_k     = sum_k_q;
  assign n_terms   = n_terms_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_macc_lane_accum.sv
// Directed bench for macc_lane_accum: a default instance, a 16-bit accumulator
// instance and an unsigned-lane instance share one stimulus stream.
module tb_macc_lane_accum;
  import macc_pkg::*;

  localparam int LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        issue_valid;
  logic        issue_last;
  logic        out_ready;
  logic [31:0] ji;
  logic [15:0] ki;

  logic [31:0] m_sum_j, m_sum_k;
  logic [9:0]  m_n;
  logic        m_ov, m_ir;
  logic [1:0]  m_st;

  logic [15:0] o_sum_j, o_sum_k;
  logic [9:0]  o_n;
  logic        o_ov, o_ir;
  logic [1:0]  o_st;

  logic [31:0] u_sum_j, u_sum_k;
  logic [9:0]  u_n;
  logic        u_ov, u_ir;
  logic [1:0]  u_st;

  macc_lane_accum dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_last(issue_last),
    .issue_ready(m_ir), .ji(ji), .ki(ki), .sum_j(m_sum_j), .sum_k(m_sum_k),
    .n_terms(m_n), .out_valid(m_ov), .out_ready(out_ready), .dbg_state(m_st)
  );

  macc_lane_accum #(.ACC_WIDTH(16)) dut_ovf (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_last(issue_last),
    .issue_ready(o_ir), .ji(ji), .ki(ki), .sum_j(o_sum_j), .sum_k(o_sum_k),
    .n_terms(o_n), .out_valid(o_ov), .out_ready(out_ready), .dbg_state(o_st)
  );

  macc_lane_accum #(.SIGN(0)) dut_uns (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_last(issue_last),
    .issue_ready(u_ir), .ji(ji), .ki(ki), .sum_j(u_sum_j), .sum_k(u_sum_k),
    .n_terms(u_n), .out_valid(u_ov), .out_ready(out_ready), .dbg_state(u_st)
  );

  // Multiplier stand-in: operands given at issue appear on ji/ki LAT cycles later,
  // with junk in between so unqualified cycles are exercised.
  logic [31:0] iss_j;
  logic [15:0] iss_k;
  logic [31:0] jp[LAT];
  logic [15:0] kp[LAT];

  always @(posedge clk) begin
    jp[0] <= iss_j;
    kp[0] <= iss_k;
    for (int i = 1; i < LAT; i++) begin
      jp[i] <= jp[i-1];
      kp[i] <= kp[i-1];
    end
  end

  assign ji = jp[LAT-1];
  assign ki = kp[LAT-1];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    iss_j = $urandom();
    iss_k = 16'($urandom());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue_term(input logic [31:0] j, input logic [15:0] k, input logic last);
    chk("issue_ready_at_issue", 32'(m_ir), 32'd1);
    issue_valid = 1'b1;
    issue_last  = last;
    iss_j       = j;
    iss_k       = k;
    step();
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    junk();
  endtask

  // Called on the cycle after the last issue; cycles are counted from that issue.
  task automatic wait_out(input string tag, input int exp_lat);
    int c;
    c = 1;
    while (!m_ov && c < 50) begin
      step();
      c++;
    end
    chk({tag, "_out_valid"}, 32'(m_ov), 32'd1);
    chk({tag, "_latency"}, 32'(c), 32'(exp_lat));
  endtask

  task automatic accept();
    out_ready = 1'b1;
    chk("handshake_issue_ready_low", 32'(m_ir), 32'd0);
    step();
    out_ready = 1'b0;
    chk("after_accept_out_valid", 32'(m_ov), 32'd0);
    chk("after_accept_issue_ready", 32'(m_ir), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bad_stable;
    int bad_ready;
    int seen_ov;

    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    out_ready   = 1'b0;
    junk();
    idle(3);
    reset = 1'b0;

    chk("reset_out_valid", 32'(m_ov), 32'd0);
    chk("reset_sum_j", m_sum_j, 32'd0);
    chk("reset_sum_k", m_sum_k, 32'd0);
    chk("reset_n_terms", 32'(m_n), 32'd0);
    chk("reset_issue_ready", 32'(m_ir), 32'd1);
    chk("reset_state", 32'(m_st), 32'(ACCUM));

    // Single vector of three terms.
    issue_term(32'd50, 16'(-40), 1'b0);
    issue_term(32'd16384, 16'(-16256), 1'b0);
    issue_term(32'd0, 16'd0, 1'b1);
    chk("drain_state", 32'(m_st), 32'(DRAIN));
    wait_out("single", LAT + 1);
    chk("single_sum_j", m_sum_j, 32'd16434);
    chk("single_sum_k", m_sum_k, 32'(-16296));
    chk("single_n_terms", 32'(m_n), 32'd3);
    chk("hold_state", 32'(m_st), 32'(HOLD));

    // Backpressure: result held for 10 cycles.
    bad_stable = 0;
    bad_ready  = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_ov !== 1'b1 || m_sum_j !== 32'd16434 || m_sum_k !== 32'(-16296) || m_n !== 10'd3)
        bad_stable++;
      if (m_ir !== 1'b0) bad_ready++;
    end
    chk("bp_outputs_stable", 32'(bad_stable), 32'd0);
    chk("bp_issue_ready_low", 32'(bad_ready), 32'd0);
    accept();

    // Same terms with 2-cycle idle gaps.
    issue_term(32'd50, 16'(-40), 1'b0);
    idle(2);
    issue_term(32'd16384, 16'(-16256), 1'b0);
    idle(2);
    issue_term(32'd0, 16'd0, 1'b1);
    wait_out("gap", LAT + 1);
    chk("gap_sum_j", m_sum_j, 32'd16434);
    chk("gap_sum_k", m_sum_k, 32'(-16296));
    chk("gap_n_terms", 32'(m_n), 32'd3);
    accept();

    // Single-term vector: -128 * -128 on both lanes.
    issue_term(32'd16384, 16'd16384, 1'b1);
    wait_out("one", LAT + 1);
    chk("one_sum_j", m_sum_j, 32'd16384);
    chk("one_sum_k", m_sum_k, 32'd16384);
    chk("one_n_terms", 32'(m_n), 32'd1);
    accept();

    // Reset one cycle after the last issue; in-flight terms must vanish.
    issue_term(32'd7, 16'd7, 1'b0);
    issue_term(32'd9, 16'd9, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_drain_issue_ready", 32'(m_ir), 32'd1);
    chk("rst_drain_state", 32'(m_st), 32'(ACCUM));
    seen_ov = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_ov !== 1'b0) seen_ov++;
      step();
    end
    chk("rst_drain_no_out_valid", 32'(seen_ov), 32'd0);
    issue_term(32'd1, 16'd1, 1'b0);
    issue_term(32'd1, 16'd1, 1'b1);
    wait_out("post_rst", LAT + 1);
    chk("post_rst_sum_j", m_sum_j, 32'd2);
    chk("post_rst_sum_k", m_sum_k, 32'd2);
    chk("post_rst_n_terms", 32'(m_n), 32'd2);
    accept();

    // Overflow of a 16-bit accumulator: 3 x 16384.
    issue_term(32'd16384, 16'd0, 1'b0);
    issue_term(32'd16384, 16'd0, 1'b0);
    issue_term(32'd16384, 16'd0, 1'b1);
    wait_out("ovf", LAT + 1);
    chk("ovf_wide_sum_j", m_sum_j, 32'd49152);
    chk("ovf_narrow_valid", 32'(o_ov), 32'd1);
`ifdef MACC_ACC_SAT_EN
    chk("ovf_narrow_sum_j", 32'(o_sum_j), 32'h0000_7FFF);
`else
    chk("ovf_narrow_sum_j", 32'(o_sum_j), 32'h0000_C000);
`endif
    chk("ovf_narrow_n_terms", 32'(o_n), 32'd3);
    accept();

    // Unsigned lanes: ki = 16'hFFF0 is 65520, signed instance sees -16.
    issue_term(32'd1, 16'hFFF0, 1'b1);
    wait_out("uns", LAT + 1);
    chk("uns_valid", 32'(u_ov), 32'd1);
    chk("uns_sum_k", u_sum_k, 32'd65520);
    chk("uns_sum_j", u_sum_j, 32'd1);
    chk("uns_n_terms", 32'(u_n), 32'd1);
    chk("signed_sum_k", m_sum_k, 32'hFFFF_FFF0);
    accept();

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/macc_lane_accum.md
# macc_lane_accum

Downstream consumer of the dual-lane int8 DSP multiplier. Each cycle the multiplier delivers one packed product pair: an upper `ji` lane (24+WIDTH bits) and a lower `ki` lane (24−WIDTH bits), both already sign-corrected. This block does four things:
- delays the issue-side valid/last flags to line up with the multiplier's pipeline latency;
- unpacks and extends the two lanes;
- accumulates each lane independently over a vector of MAC terms, i.e. two dot products sharing one input stream;
- presents the two sums on a valid/ready output toward the activation/requant stage.

## Interface
Parameters:
- `WIDTH`, 8: operand width of the multiplier; sets lane widths J_W=24+WIDTH and K_W=24−WIDTH.
- `SIGN`, 1: when 1, lanes are sign-extended; otherwise they are zero-extended.
- `MACC_LAT`, 4: cycles from operand issue at the multiplier to a valid `ji`/`ki`.
- `ACC_WIDTH`, 32: width of each accumulator and output sum; must be ≥ J_W.
- `CNT_WIDTH`, 10: width of the term counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `issue_valid`  in  1  upstream issued operands to the multiplier this cycle.
- `issue_last`  in  1  the issued operands are the final term of the vector.
- `issue_ready`  out  1  upstream may issue this cycle.
- `ji`  in  J_W  upper lane product from the multiplier.
- `ki`  in  K_W  lower lane product from the multiplier.
- `sum_j`  out  ACC_WIDTH  lane-j dot product.
- `sum_k`  out  ACC_WIDTH  lane-k dot product.
- `n_terms`  out  CNT_WIDTH  number of terms in the result.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.

## Operation
- **Issue handshake.** An issue occurs when `issue_valid && issue_ready`. An issue with `issue_valid` high and `issue_ready` low is illegal; upstream must not do it.
- **Delay line.** An MACC_LAT-deep shift register carries {valid, last}. Its tail, `term_v`/`term_l`, qualifies the `ji`/`ki` present on that same cycle.
- **Term accumulation.** On `term_v`:
  - `acc_j += ext(ji)` and `acc_k += ext(ki)`, both in ACC_WIDTH two's complement (wrap) arithmetic;
  - `cnt` increments.
- **Vector completion.** On `term_v && term_l`:
  - `sum_j`/`sum_k` load acc+term; `n_terms` loads cnt+1;
  - acc and cnt clear to 0;
  - `out_valid` sets.
- **FSM** (the state type lives in the package):
  - ACCUM: `issue_ready`=1. An issue with last → DRAIN.
  - DRAIN: `issue_ready`=0; terms still in flight keep accumulating. `term_v && term_l` → HOLD.
  - HOLD: `issue_ready`=0 and `out_valid`=1. `out_ready` → ACCUM, with `out_valid` cleared.
- **Buffering.** At most one vector is in flight past its last term, so no output buffer is needed. The cost is MACC_LAT+1 idle cycles per vector; this is accepted.
- **Output stability.** Outputs hold stable while `out_valid && !out_ready`.
- **Counter wrap.** `cnt` wraps at 2^CNT_WIDTH. No flag is raised.

## Timing
- **Reset values.** `reset` has priority over all other inputs. It clears the delay line, acc, cnt, `sum_j`, `sum_k`, `n_terms` and `out_valid` to 0, sets state to ACCUM, and drives `issue_ready`=1 from the first cycle after reset.
- **Reset mid-vector or mid-drain.** In-flight terms are discarded. Any `ji`/`ki` still arriving are ignored, because the delay line has been cleared.
- **Latency.** Issue of the last term at cycle t gives `out_valid` at t+MACC_LAT+1.
- **Single-term vector.** `issue_valid && issue_last` on the first term gives `n_terms`=1.
- **Handshake cycle.** On the cycle where `out_valid && out_ready`, `issue_ready` is still 0. Issue resumes on the next cycle.
- **Idle cycles.** `issue_valid`=0 gaps inside a vector are legal. Accumulation simply pauses.

## Configuration
- `MACC_ACC_SAT_EN` defined:
  - the lane adds saturate to ±(2^(ACC_WIDTH−1)) limits, i.e. max = 2^(ACC_WIDTH−1)−1 and min = −2^(ACC_WIDTH−1);
  - with `SIGN`≠1, they saturate to [0, 2^(ACC_WIDTH−1)−1];
  - saturation is sticky within a vector, because saturated values keep clamping.
- `MACC_ACC_SAT_EN` undefined: plain wrap-around adds.

## Structure
- **Shared package `macc_pkg`:** the lane widths J_W and K_W as functions of WIDTH, the `acc_state_t` enum {ACCUM, DRAIN, HOLD}, and the saturating-add function.
- **Sub-module `macc_valid_pipe`:** a parameterised MACC_LAT-deep {valid, last} shift register with synchronous reset. The top level contains the FSM, the extension logic and the accumulators.

## Test plan
- **Single vector.** Three terms (ji,ki) = (50,−40), (16384,−16256), (0,0), with last on term 3 → `out_valid` at issue3+5; `sum_j`=16434, `sum_k`=−16296, `n_terms`=3.
- **Backpressure.** Hold `out_ready`=0 for 10 cycles → outputs stable, `issue_ready`=0 throughout. Raise `out_ready` → `issue_ready`=1 on the next cycle, and the next vector starts from acc=0.
- **Gaps and single-term vector.**
  - Idle gaps of 2 cycles between terms → same sums as gapless.
  - A single-term vector (−128·−128) → `sum_j`=16384, `n_terms`=1.
- **Reset mid-DRAIN.** Assert reset one cycle after issuing last → `out_valid` never rises. The next vector of (1,1)×2 yields sums 2/2.
- **Overflow** (ACC_WIDTH=16, three j terms of 16384):
  - without `MACC_ACC_SAT_EN` → `sum_j`=−16384;
  - with it → `sum_j`=32767.
- **Unsigned mode.** `SIGN`=0, ki=16'hFFF0 → extended as 65520, not −16.
